// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the MEM-stage data-memory port: issues one word-aligned access
// with byte enables, waits for mem_ack, and returns extended load data. Optional: MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       rdata_q, rdata_nxt;
    logic              fault_q, fault_nxt;

    logic              q_write;
    logic [1:0]        q_size;
    logic              q_unsigned;
    logic [ADDR_W-1:0] q_addr;
    logic [31:0]       q_wdata;

    logic              handshake, misaligned, req_illegal, issuing;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [31:0]       wdata_fmt, ld_ext;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign req_ready = (state == IDLE) && !rst;
    assign handshake = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif
    assign req_illegal = (req_size == 2'b11) || misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_write    <= 1'b0;
            q_size     <= 2'b00;
            q_unsigned <= 1'b0;
            q_addr     <= '0;
            q_wdata    <= '0;
        end else if (handshake) begin
            q_write    <= req_write;
            q_size     <= req_size;
            q_unsigned <= req_unsigned;
            q_addr     <= req_addr;
            q_wdata    <= req_wdata;
        end
    end

    // Without the trap, sub-size offset bits are dropped so lanes stay naturally aligned.
    always_comb begin
        off       = 2'b00;
        be        = 4'b1111;
        wdata_fmt = q_wdata;
        case (q_size)
            2'b00: begin
                off       = q_addr[1:0];
                be        = 4'b0001 << off;
                wdata_fmt = {4{q_wdata[7:0]}};
            end
            2'b01: begin
                off       = {q_addr[1], 1'b0};
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{q_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off)
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            2'd3:    lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (q_size)
            2'b00:   ld_ext = {{24{lane_b[7] & ~q_unsigned}}, lane_b};
            2'b01:   ld_ext = {{16{lane_h[15] & ~q_unsigned}}, lane_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
            fault_q <= fault_nxt;
        end
    end

    // An ack on the final timeout cycle takes priority over the fault.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata_q;
        fault_nxt = fault_q;
        case (state)
            IDLE: begin
                if (handshake) begin
                    cnt_nxt   = '0;
                    rdata_nxt = '0;
                    fault_nxt = req_illegal;
                    state_nxt = req_illegal ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    rdata_nxt = q_write ? 32'd0 : ld_ext;
                    fault_nxt = 1'b0;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    rdata_nxt = '0;
                    fault_nxt = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign issuing   = (state == ISSUE);
    assign stall     = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_fault = rsp_valid && fault_q;
    assign mem_req   = issuing;
    assign mem_we    = issuing && q_write;
    assign mem_be    = issuing ? be : 4'b0000;
    assign mem_addr  = issuing ? {q_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = (issuing && q_write) ? wdata_fmt : 32'd0;

endmodule
